// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and request check for lsu_subword
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Returns 1 when a request must be answered with an error and never touch memory.
  function automatic logic req_error(input logic        store,
                                     input logic [2:0]  f3,
                                     input logic [31:0] addr,
                                     input logic [31:0] words);
    logic legal;
    logic misal;
    logic oor;
    if (store) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    else       legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    misal = (((f3 == F3_H) || (f3 == F3_HU)) && addr[0]) ||
            ((f3 == F3_W) && (addr[1:0] != 2'b00));
    oor   = {2'b00, addr[31:2]} >= words;
    return !legal || misal || oor;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane extract (loads) and lane merge (sub-word stores)
// Ports:
//   i_word    : word read from memory
//   i_wdata   : store data (low byte/half used for sb/sh)
//   i_lane    : byte offset addr[1:0]
//   i_funct3  : load/store size and signedness
//   o_extract : sign/zero-extended load result
//   o_merge   : i_word with the addressed lane replaced by store data
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_word,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [1:0]      i_lane,
  input  logic [2:0]      i_funct3,
  output logic [XLEN-1:0] o_extract,
  output logic [XLEN-1:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_extract = i_word;
    case (i_funct3)
      F3_B:    o_extract = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_extract = {{16{w_half[15]}}, w_half};
      F3_BU:   o_extract = {24'h0, w_byte};
      F3_HU:   o_extract = {16'h0, w_half};
      default: o_extract = i_word;
    endcase
  end

  always_comb begin
    o_merge = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_lane)
          2'd0:    o_merge[7:0]   = i_wdata[7:0];
          2'd1:    o_merge[15:8]  = i_wdata[7:0];
          2'd2:    o_merge[23:16] = i_wdata[7:0];
          default: o_merge[31:24] = i_wdata[7:0];
        endcase
      end
      F3_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// rtl/lsu_subword.sv - byte/halfword load-store unit in front of a word-only data memory
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_req_*/o_req_ready     : core request (valid/ready, accepted only in IDLE)
//   o_resp_done/err/rdata   : one-cycle completion pulse, error flag, load data
//   o_mem_a/wd/we, i_mem_rd : word memory (async read, sync full-word write)
module lsu_subword
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int XLEN      = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_store,
  input  logic [2:0]      i_req_funct3,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_done,
  output logic            o_resp_err,
  output logic [XLEN-1:0] o_resp_rdata,
  output logic [XLEN-1:0] o_mem_a,
  output logic [XLEN-1:0] o_mem_wd,
  output logic            o_mem_we,
  input  logic [XLEN-1:0] i_mem_rd
);

  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

  state_t          r_state;
  state_t          w_next;
  logic            r_store;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic            r_err;
  logic [XLEN-1:0] r_merge;
  logic [XLEN-1:0] r_rdata;

  logic            w_req_err;
  logic            w_accept;
  logic [XLEN-1:0] w_extract;
  logic [XLEN-1:0] w_merge;

  assign w_req_err = req_error(i_req_store, i_req_funct3, i_req_addr, LP_WORDS);
  assign w_accept  = (r_state == IDLE) && i_req_valid;

  // One aligner serves both LOAD (extract) and RMW_RD (merge); both look at the latched request.
  lsu_align #(.XLEN(XLEN)) u_align (
    .i_word    (i_mem_rd),
    .i_wdata   (r_wdata),
    .i_lane    (r_addr[1:0]),
    .i_funct3  (r_funct3),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_req_valid) begin
          if (w_req_err)                  w_next = RESP;
          else if (!i_req_store)          w_next = LOAD;
          else if (i_req_funct3 == F3_W)  w_next = WRITE;
          else                            w_next = RMW_RD;
        end
      end
      LOAD:    w_next = RESP;
      RMW_RD:  w_next = WRITE;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
      r_merge  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_accept) begin
        r_store  <= i_req_store;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == LOAD)   r_rdata <= w_extract;
      if (r_state == RMW_RD) r_merge <= w_merge;
    end
  end

  // Write enable and done are gated by reset so an in-flight request dies without side effects.
  always_comb begin
    o_req_ready = (r_state == IDLE);
    o_resp_done = 1'b0;
    o_resp_err  = 1'b0;
    o_mem_a     = '0;
    o_mem_wd    = '0;
    o_mem_we    = 1'b0;
    case (r_state)
      LOAD, RMW_RD: begin
        o_mem_a = {r_addr[XLEN-1:2], 2'b00};
      end
      WRITE: begin
        o_mem_a  = {r_addr[XLEN-1:2], 2'b00};
        o_mem_we = !i_reset;
        o_mem_wd = (r_store && (r_funct3 == F3_W)) ? r_wdata : r_merge;
      end
      RESP: begin
        o_resp_done = !i_reset;
        o_resp_err  = r_err && !i_reset;
      end
      default: ;
    endcase
  end

  assign o_resp_rdata = r_rdata;

endmodule

// File: tb/tb_lsu_subword.sv
// tb/tb_lsu_subword.sv - directed self-checking bench for lsu_subword with a 64-word memory model
module tb_lsu_subword;
  import lsu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_done;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [64];
  logic        mem_clr;
  int          we_cnt;
  logic [31:0] last_wd;
  int          acc_cnt;
  int          tests;
  int          fails;

  lsu_subword #(.MEM_WORDS(64), .XLEN(32)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_store  (req_store),
    .i_req_funct3 (req_funct3),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_done  (resp_done),
    .o_resp_err   (resp_err),
    .o_resp_rdata (resp_rdata),
    .o_mem_a      (mem_a),
    .o_mem_wd     (mem_wd),
    .o_mem_we     (mem_we),
    .i_mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      we_cnt  <= 0;
      last_wd <= 32'h0;
      acc_cnt <= 0;
    end else begin
      if (mem_we) begin
        mem[mem_a[7:2]] <= mem_wd;
        we_cnt          <= we_cnt + 1;
        last_wd         <= mem_wd;
      end
      if (req_valid && req_ready && !reset) acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd);
    lat = 0;
    err = 1'b0;
    rd  = 32'h0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (resp_done) begin
        lat = c;
        err = resp_err;
        rd  = resp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_clr = 1'b1; req_valid = 1'b0;
    req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    tests++; if (resp_done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", resp_done); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", resp_err); end
    tests++; if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
    tests++; if (mem_we !== 1'b0 || mem_a !== 32'h0 || mem_wd !== 32'h0) begin
      fails++; $display("FAIL reset_mem we=%b a=%h wd=%h exp=0/0/0", mem_we, mem_a, mem_wd);
    end
  endtask

  task automatic test_word();
    int lat; logic err; logic [31:0] rd; int w0;
    do_req(1'b1, F3_W, 32'h0, 32'hFACEFACE, lat, err, rd);
    tests++; if (lat !== 2 || err !== 1'b0) begin fails++; $display("FAIL sw_preload lat=%0d err=%b exp=2/0", lat, err); end
    @(negedge clk);
    tests++; if (mem[0] !== 32'hFACEFACE) begin fails++; $display("FAIL sw_preload_mem got=%h exp=facefface", mem[0]); end
    w0 = we_cnt;
    do_req(1'b0, F3_W, 32'h0, 32'h0, lat, err, rd);
    tests++; if (rd !== 32'hFACEFACE || lat !== 2 || err !== 1'b0) begin
      fails++; $display("FAIL lw rd=%h lat=%0d err=%b exp=facefface/2/0", rd, lat, err);
    end
    @(negedge clk);
    tests++; if (resp_done !== 1'b0) begin fails++; $display("FAIL lw_done_pulse got=%b exp=0", resp_done); end
    tests++; if (we_cnt !== w0) begin fails++; $display("FAIL lw_no_write we=%0d exp=%0d", we_cnt, w0); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3 [6]  = '{F3_B, F3_BU, F3_H, F3_B, F3_H, F3_HU};
    logic [31:0] ad [6]  = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h0, 32'h2};
    logic [31:0] ex [6]  = '{32'hFFFFFFCE, 32'h000000FA, 32'hFFFFFACE,
                             32'hFFFFFFFA, 32'hFFFFFACE, 32'h0000FACE};
    int lat; logic err; logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, f3[i], ad[i], 32'h0, lat, err, rd);
      tests++;
      if (rd !== ex[i] || lat !== 2 || err !== 1'b0) begin
        fails++; $display("FAIL load%0d rd=%h lat=%0d err=%b exp=%h/2/0", i, rd, lat, err, ex[i]);
      end
    end
  endtask

  task automatic test_subword_store();
    int lat; logic err; logic [31:0] rd; int w0;
    w0 = we_cnt;
    do_req(1'b1, F3_B, 32'h1, 32'h00000012, lat, err, rd);
    tests++; if (lat !== 3 || err !== 1'b0) begin fails++; $display("FAIL sb lat=%0d err=%b exp=3/0", lat, err); end
    tests++; if (we_cnt !== w0 + 1 || last_wd !== 32'hFACE12CE) begin
      fails++; $display("FAIL sb_write cnt=%0d wd=%h exp=%0d/face12ce", we_cnt - w0, last_wd, 1);
    end
    tests++; if (rd !== 32'h0000FACE) begin fails++; $display("FAIL sb_keeps_rdata got=%h exp=0000face", rd); end
    do_req(1'b0, F3_W, 32'h0, 32'h0, lat, err, rd);
    tests++; if (rd !== 32'hFACE12CE) begin fails++; $display("FAIL sb_readback got=%h exp=face12ce", rd); end
    do_req(1'b1, F3_H, 32'h2, 32'h1234BEEF, lat, err, rd);
    tests++; if (lat !== 3 || last_wd !== 32'hBEEF12CE) begin
      fails++; $display("FAIL sh lat=%0d wd=%h exp=3/beef12ce", lat, last_wd);
    end
  endtask

  task automatic test_errors();
    logic        st [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [6] = '{F3_H, F3_W, F3_W, 3'b011, F3_BU, F3_HU};
    logic [31:0] ad [6] = '{32'h1, 32'h2, 32'h100, 32'h0, 32'h0, 32'h3};
    int lat; logic err; logic [31:0] rd; int w0;
    w0 = we_cnt;
    for (int i = 0; i < 6; i++) begin
      do_req(st[i], f3[i], ad[i], 32'h55555555, lat, err, rd);
      tests++;
      if (lat !== 1 || err !== 1'b1) begin
        fails++; $display("FAIL err%0d lat=%0d err=%b exp=1/1", i, lat, err);
      end
    end
    tests++; if (we_cnt !== w0) begin fails++; $display("FAIL err_no_write we=%0d exp=%0d", we_cnt, w0); end
  endtask

  task automatic test_sw_and_reset();
    int lat; logic err; logic [31:0] rd; int w0; int dn;
    do_req(1'b1, F3_W, 32'hFC, 32'h00000063, lat, err, rd);
    @(negedge clk);
    tests++; if (lat !== 2 || mem[63] !== 32'h00000063) begin
      fails++; $display("FAIL sw63 lat=%0d mem=%h exp=2/00000063", lat, mem[63]);
    end
    w0 = we_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_H; req_addr = 32'h0; req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_rmw_ready got=%b exp=1", req_ready); end
    dn = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_done) dn++;
      @(negedge clk);
    end
    tests++; if (dn !== 0) begin fails++; $display("FAIL rst_rmw_done got=%0d exp=0", dn); end
    tests++; if (mem[0] !== 32'hBEEF12CE || we_cnt !== w0) begin
      fails++; $display("FAIL rst_rmw_mem got=%h we=%0d exp=beef12ce/%0d", mem[0], we_cnt - w0, 0);
    end
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B; req_addr = 32'h0; req_wdata = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL rst_write_we got=%b exp=0", mem_we); end
    @(negedge clk);
    reset = 1'b0;
    tests++; if (mem[0] !== 32'hBEEF12CE || we_cnt !== w0 || resp_rdata !== 32'h0) begin
      fails++; $display("FAIL rst_write_mem got=%h we=%0d rdata=%h exp=beef12ce/0/0", mem[0], we_cnt - w0, resp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int issued; int dcnt; int a0; int w0;
    logic [31:0] got [6];
    issued = 0; dcnt = 0; a0 = acc_cnt; w0 = we_cnt;
    for (int c = 0; c < 200 && dcnt < 6; c++) begin
      @(negedge clk);
      if (resp_done) begin
        got[dcnt] = resp_rdata;
        dcnt++;
      end
      req_valid = 1'b1;
      if (dcnt == 6) begin
        req_valid = 1'b0;
      end else if (req_ready && issued < 6) begin
        req_store  = (issued % 2 == 0);
        req_funct3 = F3_W;
        req_addr   = (issued % 2 == 0) ? 32'(4 * (10 + issued)) : 32'(4 * (9 + issued));
        req_wdata  = 32'h1000 + 32'(issued);
        issued++;
      end else if (req_ready) begin
        req_valid = 1'b0;
      end else begin
        req_store = 1'b1; req_funct3 = F3_W; req_addr = 32'h50; req_wdata = 32'hBAD;
      end
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (dcnt !== 6 || acc_cnt - a0 !== 6) begin
      fails++; $display("FAIL b2b_count done=%0d acc=%0d exp=6/6", dcnt, acc_cnt - a0);
    end
    tests++; if (mem[20] !== 32'h0 || we_cnt - w0 !== 3) begin
      fails++; $display("FAIL b2b_capture mem20=%h writes=%0d exp=0/3", mem[20], we_cnt - w0);
    end
    tests++; if (got[1] !== 32'h1000 || got[3] !== 32'h1002 || got[5] !== 32'h1004) begin
      fails++; $display("FAIL b2b_loads %h %h %h exp=1000/1002/1004", got[1], got[3], got[5]);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_word();
    test_loads();
    test_subword_store();
    test_errors();
    test_sw_and_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
